// File: rtl/mole_scheduler.sv
// mole_scheduler
//   Per-round controller for a multi-hole whack-a-mole game. While the game
//   is running it picks a pseudo-random hole, lights that mole for an
//   up-window and then darkens the field for a down-window. Button rises on
//   the lit hole count as hits. Hits raise the score and shorten the next
//   up-window. A window that expires without a hit counts as a miss.
//
// Ports
//   clk                   system clock
//   reset_button_pressed  synchronous active-high reset
//   game_in_progress      level from the game FSM, 1 = playing
//   ms_tick               one-cycle strobe every millisecond
//   hit_buttons           synchronised and debounced button levels, one per hole
//   mole_leds             one-hot raised mole, or 0 when no mole is up
//   mole_idx              index of the current (or last) mole
//   score                 hits in this game, saturating at all-ones
//   hit_pulse             one-cycle strobe when a hit is registered
//   miss_pulse            one-cycle strobe when an up-window expires unhit
module mole_scheduler #(
  parameter int          N_HOLES      = 8,
  parameter int          MOLE_UP_MS   = 1000,
  parameter int          MOLE_DOWN_MS = 1000,
  parameter int          MIN_UP_MS    = 300,
  parameter int          SPEEDUP_MS   = 50,
  parameter int          SCORE_W      = 8,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic                       clk,
  input  logic                       reset_button_pressed,
  input  logic                       game_in_progress,
  input  logic                       ms_tick,
  input  logic [N_HOLES-1:0]         hit_buttons,
  output logic [N_HOLES-1:0]         mole_leds,
  output logic [$clog2(N_HOLES)-1:0] mole_idx,
  output logic [SCORE_W-1:0]         score,
  output logic                       hit_pulse,
  output logic                       miss_pulse
);

  localparam int IW    = $clog2(N_HOLES);
  localparam int MAX_L = (MOLE_UP_MS > MOLE_DOWN_MS) ? MOLE_UP_MS : MOLE_DOWN_MS;
  localparam int TW    = $clog2(MAX_L + 1);

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [15:0] SEED_EFF = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

  typedef enum logic [1:0] {IDLE, PICK, UP, DOWN} state_t;

  state_t            state, state_nxt;
  logic [TW-1:0]     timer, timer_nxt;
  logic [TW-1:0]     up_len, up_len_nxt;
  logic [SCORE_W-1:0] score_nxt;
  logic [IW-1:0]     idx_nxt;
  logic [IW-1:0]     last_idx, last_nxt;
  logic [N_HOLES-1:0] leds_nxt;
  logic              hit_nxt, miss_nxt;
  logic [15:0]       lfsr;
  logic [N_HOLES-1:0] btn_q;
  logic [N_HOLES-1:0] rise;
  logic [IW-1:0]     cand;
  logic              expire;

  // Score increment that holds at all-ones instead of wrapping.
  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Shorten the up-window by one speed-up step, clamped at the floor.
  function automatic logic [TW-1:0] shrink_up(input logic [TW-1:0] v);
    int vi;
    vi = int'(v);
    if (vi - SPEEDUP_MS > MIN_UP_MS)
      return TW'(vi - SPEEDUP_MS);
    else
      return TW'(MIN_UP_MS);
  endfunction

  // Galois LFSR, shift right, taps 16'hB400. A non-zero state never
  // steps to zero.
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  assign rise   = hit_buttons & ~btn_q;
  assign expire = ms_tick && (timer == TW'(1));

  always_comb begin
    state_nxt  = state;
    timer_nxt  = timer;
    up_len_nxt = up_len;
    score_nxt  = score;
    idx_nxt    = mole_idx;
    last_nxt   = last_idx;
    leds_nxt   = mole_leds;
    hit_nxt    = 1'b0;
    miss_nxt   = 1'b0;

    // Skip the previous hole so the same mole never appears twice in a row.
    cand = lfsr[IW-1:0];
    if (cand == last_idx)
      cand = cand + 1'b1;

    if (ms_tick && (timer != '0))
      timer_nxt = timer - 1'b1;

    case (state)
      IDLE: begin
        leds_nxt  = '0;
        timer_nxt = '0;
        if (game_in_progress) begin
          state_nxt  = PICK;
          score_nxt  = '0;
          up_len_nxt = TW'(MOLE_UP_MS);
        end
      end
      PICK: begin
        if (!game_in_progress) begin
          state_nxt = IDLE;
          leds_nxt  = '0;
        end else begin
          idx_nxt        = cand;
          last_nxt       = cand;
          timer_nxt      = up_len;
          leds_nxt       = '0;
          leds_nxt[cand] = 1'b1;
          state_nxt      = UP;
        end
      end
      UP: begin
        // Abort outranks a hit, and a hit outranks expiry.
        if (!game_in_progress) begin
          state_nxt = IDLE;
          leds_nxt  = '0;
        end else if (rise[mole_idx]) begin
          hit_nxt    = 1'b1;
          score_nxt  = sat_inc(score);
          up_len_nxt = shrink_up(up_len);
          timer_nxt  = TW'(MOLE_DOWN_MS);
          leds_nxt   = '0;
          state_nxt  = DOWN;
        end else if (expire) begin
          miss_nxt  = 1'b1;
          timer_nxt = TW'(MOLE_DOWN_MS);
          leds_nxt  = '0;
          state_nxt = DOWN;
        end
      end
      DOWN: begin
        leds_nxt = '0;
        if (!game_in_progress)
          state_nxt = IDLE;
        else if (expire)
          state_nxt = PICK;
      end
      default: begin
        state_nxt = IDLE;
        leds_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_button_pressed) begin
      state      <= IDLE;
      timer      <= '0;
      up_len     <= TW'(MOLE_UP_MS);
      score      <= '0;
      mole_idx   <= '0;
      last_idx   <= '0;
      mole_leds  <= '0;
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
      lfsr       <= SEED_EFF;
      btn_q      <= '0;
    end else begin
      state      <= state_nxt;
      timer      <= timer_nxt;
      up_len     <= up_len_nxt;
      score      <= score_nxt;
      mole_idx   <= idx_nxt;
      last_idx   <= last_nxt;
      mole_leds  <= leds_nxt;
      hit_pulse  <= hit_nxt;
      miss_pulse <= miss_nxt;
      lfsr       <= lfsr_step(lfsr);
      btn_q      <= hit_buttons;
    end
  end

endmodule

// File: tb/tb_mole_scheduler.sv
module tb_mole_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       gip;
  logic       tick;
  logic [3:0] btn;

  logic [3:0] leds;
  logic [1:0] idx;
  logic [7:0] score;
  logic       hit, miss;

  logic [3:0] leds2;
  logic [1:0] idx2;
  logic [1:0] score2;
  logic       hit2, miss2;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] m_lfsr, m_prev;
  int          m_last;
  int          exp_score;
  int          seq_a[5];
  int          seq_b[5];

  mole_scheduler #(
    .N_HOLES(4), .MOLE_UP_MS(4), .MOLE_DOWN_MS(2), .MIN_UP_MS(2),
    .SPEEDUP_MS(1), .SCORE_W(8), .LFSR_SEED(16'hACE1)
  ) dut (
    .clk(clk), .reset_button_pressed(rst), .game_in_progress(gip),
    .ms_tick(tick), .hit_buttons(btn), .mole_leds(leds), .mole_idx(idx),
    .score(score), .hit_pulse(hit), .miss_pulse(miss)
  );

  // Narrow score copy, fed the same stimulus, to exercise saturation.
  mole_scheduler #(
    .N_HOLES(4), .MOLE_UP_MS(4), .MOLE_DOWN_MS(2), .MIN_UP_MS(2),
    .SPEEDUP_MS(1), .SCORE_W(2), .LFSR_SEED(16'hACE1)
  ) dut2 (
    .clk(clk), .reset_button_pressed(rst), .game_in_progress(gip),
    .ms_tick(tick), .hit_buttons(btn), .mole_leds(leds2), .mole_idx(idx2),
    .score(score2), .hit_pulse(hit2), .miss_pulse(miss2)
  );

  always #5 clk = ~clk;

  // Reference LFSR; m_prev holds the value seen during the previous cycle.
  always @(posedge clk) begin
    if (rst) m_lfsr <= 16'hACE1;
    else     m_lfsr <= m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
    m_prev <= m_lfsr;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_pick(input logic [15:0] l, input int last);
    int c;
    c = int'(l[1:0]);
    if (c == last) c = (c + 1) % 4;
    return c;
  endfunction

  task automatic pick_check();
    int e;
    e = exp_pick(m_prev, m_last);
    chk("pick_idx", int'(idx), e);
    chk("pick_leds", int'(leds), 1 << e);
    m_last = e;
  endtask

  task automatic up_expire(input int len);
    for (int i = 1; i < len; i++) begin
      step();
      chk("up_lit", int'(leds), 1 << m_last);
      chk("up_nomiss", int'(miss), 0);
    end
    step();
    chk("exp_miss", int'(miss), 1);
    chk("exp_nohit", int'(hit), 0);
    chk("exp_dark", int'(leds), 0);
    chk("exp_score", int'(score), exp_score);
  endtask

  task automatic down_to_pick();
    step();
    chk("down_nohit", int'(hit), 0);
    chk("down_nomiss", int'(miss), 0);
    chk("down_dark", int'(leds), 0);
    step();
    chk("down_dark2", int'(leds), 0);
    step();
    pick_check();
  endtask

  task automatic hit_round(input int d);
    for (int i = 0; i < d; i++) begin
      step();
      chk("hr_lit", int'(leds), 1 << m_last);
    end
    btn = 4'(1 << m_last);
    step();
    chk("hit_pulse", int'(hit), 1);
    chk("hit_nomiss", int'(miss), 0);
    chk("hit_dark", int'(leds), 0);
    exp_score++;
    chk("hit_score", int'(score), exp_score);
    chk("hit_score2", int'(score2), (exp_score > 3) ? 3 : exp_score);
    btn = 4'b0000;
  endtask

  task automatic play_seq(output int seq[5]);
    rst = 1'b1; gip = 1'b0; btn = 4'b0000;
    step();
    step();
    rst = 1'b0; gip = 1'b1;
    m_last = 0; exp_score = 0;
    step();
    step();
    pick_check();
    seq[0] = int'(idx);
    for (int k = 1; k < 5; k++) begin
      up_expire(4);
      down_to_pick();
      seq[k] = int'(idx);
    end
  endtask

  initial begin
    int picks, repeats, model_err, cyc, prev_idx, e;
    logic [3:0] seen, prev_leds;

    rst = 1'b1; gip = 1'b0; tick = 1'b1; btn = 4'b0000;
    m_last = 0; exp_score = 0;
    step();
    step();
    chk("rst_leds", int'(leds), 0);
    chk("rst_idx", int'(idx), 0);
    chk("rst_score", int'(score), 0);
    chk("rst_hit", int'(hit), 0);
    chk("rst_miss", int'(miss), 0);

    // Unattended round: full up-window, miss, dark gap, new hole.
    rst = 1'b0; gip = 1'b1;
    step();
    chk("pick_cycle_dark", int'(leds), 0);
    step();
    pick_check();
    up_expire(4);
    down_to_pick();
    chk("t1_score", int'(score), 0);

    // Hits shrink the window 4 -> 3 -> 2, then it stays at the floor.
    hit_round(2);
    down_to_pick();
    up_expire(3);
    down_to_pick();
    hit_round(1);
    down_to_pick();
    hit_round(1);
    down_to_pick();
    up_expire(2);
    down_to_pick();

    // Wrong hole during UP, then buttons held through DOWN into UP.
    btn = 4'(~(1 << m_last));
    up_expire(2);
    btn = 4'b1111;
    down_to_pick();
    up_expire(2);
    btn = 4'b0000;
    down_to_pick();
    chk("t3_score", int'(score), 3);

    // Hits on the expiry cycle; narrow score saturates.
    hit_round(1);
    down_to_pick();
    hit_round(1);
    chk("sat_score2", int'(score2), 3);
    down_to_pick();

    // Abort in the same cycle as a hit.
    btn = 4'(1 << m_last);
    gip = 1'b0;
    step();
    chk("abort_nohit", int'(hit), 0);
    chk("abort_nomiss", int'(miss), 0);
    chk("abort_dark", int'(leds), 0);
    chk("abort_score", int'(score), 5);
    step();
    chk("idle_dark", int'(leds), 0);
    chk("idle_hold", int'(score), 5);
    btn = 4'b0000;
    gip = 1'b1;
    step();
    chk("restart_clear", int'(score), 0);
    chk("restart_clear2", int'(score2), 0);
    exp_score = 0;
    step();
    pick_check();
    up_expire(4);
    down_to_pick();

    // Reset in UP beats a simultaneous hit.
    step();
    btn = 4'(1 << m_last);
    rst = 1'b1;
    step();
    chk("mid_rst_leds", int'(leds), 0);
    chk("mid_rst_idx", int'(idx), 0);
    chk("mid_rst_score", int'(score), 0);
    chk("mid_rst_hit", int'(hit), 0);
    chk("mid_rst_miss", int'(miss), 0);

    play_seq(seq_a);
    play_seq(seq_b);
    for (int k = 0; k < 5; k++) chk("replay_idx", seq_b[k], seq_a[k]);

    // Long run: no back-to-back repeats, every hole used.
    picks = 0; repeats = 0; model_err = 0; cyc = 0; seen = 4'b0000;
    prev_idx = int'(idx); prev_leds = leds;
    while (picks < 1000 && cyc < 10000) begin
      step();
      cyc++;
      if (prev_leds == 4'b0000 && leds != 4'b0000) begin
        picks++;
        if (int'(idx) == prev_idx) repeats++;
        seen[idx] = 1'b1;
        e = exp_pick(m_prev, m_last);
        if (int'(idx) != e) model_err++;
        m_last = e;
        prev_idx = int'(idx);
      end
      prev_leds = leds;
    end
    chk("long_picks", picks, 1000);
    chk("long_repeats", repeats, 0);
    chk("long_seen", int'(seen), 15);
    chk("long_model", model_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
